// File: rtl/loop_seq_pkg.sv
// Shared types for the loop sequencer: FSM states and the two descriptor mode bits.
package loop_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_state_t;

  typedef enum logic {
    ADD = 1'b0,
    MUL = 1'b1
  } step_mode_t;

  typedef enum logic {
    EXCL = 1'b0,
    INCL = 1'b1
  } bound_mode_t;

endpackage

// File: rtl/loop_seq_next.sv
// Combinational next-index unit: computes the following index, detects overflow
// and degenerate steps, and decides whether the current index is the final one.
module loop_seq_next
  import loop_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             mul,
  input  logic             incl,
  output logic [WIDTH-1:0] nxt,
  output logic             overflow,
  output logic             degen,
  output logic             last
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               in_bound;

  // Both results are computed wide so the bits above WIDTH flag overflow.
  assign sum  = {1'b0, cur} + {1'b0, step};
  assign prod = {{WIDTH{1'b0}}, cur} * {{WIDTH{1'b0}}, step};

  always_comb begin
    nxt      = sum[WIDTH-1:0];
    overflow = sum[WIDTH];
    if (step_mode_t'(mul) == MUL) begin
      nxt      = prod[WIDTH-1:0];
      overflow = |prod[2*WIDTH-1:WIDTH];
    end
  end

  assign degen    = (nxt == cur);
  assign in_bound = (bound_mode_t'(incl) == INCL) ? (nxt <= limit) : (nxt < limit);
  assign last     = !in_bound || overflow || degen;

endmodule

// File: rtl/loop_sequencer.sv
// Sequential for-loop: accepts one descriptor, streams indices over valid/ready,
// and stops on bound, overflow, degenerate step or a consumer break.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             cfg_mul,
  input  logic             cfg_incl,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [WIDTH-1:0] idx,
  output logic             idx_last,
  input  logic             brk,
  output logic             done,
  output logic             brk_seen,
  output logic             err_degen,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // idx_valid is never withdrawn and idx/idx_last hold until it is taken.

  loop_state_t      state, state_nxt;
  logic [WIDTH-1:0] cur, step_q, limit_q;
  logic             mul_q, incl_q;
  logic [WIDTH-1:0] nxt;
  logic             overflow, degen, last;
  logic             start_ok, hs;

  loop_seq_next #(.WIDTH(WIDTH)) u_next (
    .cur      (cur),
    .step     (step_q),
    .limit    (limit_q),
    .mul      (mul_q),
    .incl     (incl_q),
    .nxt      (nxt),
    .overflow (overflow),
    .degen    (degen),
    .last     (last)
  );

  assign start_ok = cfg_incl ? (cfg_start <= cfg_limit) : (cfg_start < cfg_limit);
  assign hs       = (state == RUN) && idx_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = start_ok ? RUN : DONE;
      RUN:     if (hs && (brk || last)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= '0;
      step_q    <= '0;
      limit_q   <= '0;
      mul_q     <= 1'b0;
      incl_q    <= 1'b0;
      brk_seen  <= 1'b0;
      err_degen <= 1'b0;
    end else if (state == IDLE && cfg_valid) begin
      cur       <= cfg_start;
      step_q    <= cfg_step;
      limit_q   <= cfg_limit;
      mul_q     <= cfg_mul;
      incl_q    <= cfg_incl;
      brk_seen  <= 1'b0;
      err_degen <= 1'b0;
    end else if (hs) begin
      // A break wins over a natural end, so err_degen stays clear on a break.
      if (brk)       brk_seen  <= 1'b1;
      else if (last) err_degen <= overflow || degen;
      else           cur       <= nxt;
    end
  end

  assign cfg_ready = (state == IDLE);
  assign idx_valid = (state == RUN);
  assign idx       = cur;
  assign idx_last  = (state == RUN) && last;
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: directed and random descriptors checked against a
// 64-bit arithmetic model of the loop, plus literal pins of the model results.
module tb_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_start = '0, cfg_limit = '0, cfg_step = '0;
  logic        cfg_mul = 1'b0, cfg_incl = 1'b0;
  logic        idx_valid;
  logic        idx_ready = 1'b0;
  logic [31:0] idx;
  logic        idx_last;
  logic        brk = 1'b0;
  logic        done, brk_seen, err_degen;
  logic [1:0]  fsm_state;

  int vec  = 0;
  int miss = 0;

  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] seen_q[$];

  loop_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_limit (cfg_limit),
    .cfg_step  (cfg_step),
    .cfg_mul   (cfg_mul),
    .cfg_incl  (cfg_incl),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_last  (idx_last),
    .brk       (brk),
    .done      (done),
    .brk_seen  (brk_seen),
    .err_degen (err_degen),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vec++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference loop: plain 64-bit arithmetic, fills the expected index queue.
  task automatic model(input logic [31:0] s, l, st, input bit m, inc, output bit err);
    longint unsigned c, n;
    bit fin, ovf, deg, inb;
    exp_q.delete();
    exp_last_q.delete();
    err = 1'b0;
    c = s;
    if (inc ? (c > l) : (c >= l)) return;
    for (int k = 0; k < 5000; k++) begin
      n   = m ? c * st : c + st;
      ovf = n > 64'hFFFF_FFFF;
      n   = n & 64'hFFFF_FFFF;
      deg = (n == c);
      inb = inc ? (n <= l) : (n < l);
      fin = ovf || deg || !inb;
      exp_q.push_back(c[31:0]);
      exp_last_q.push_back(fin);
      if (fin) begin
        err = ovf || deg;
        return;
      end
      c = n;
    end
  endtask

  // Compare process: every cycle the stream is valid, check against the model front.
  always @(negedge clk) begin
    if (rst && idx_valid) begin
      if (exp_q.size() == 0) begin
        vec++;
        miss++;
        $display("FAIL unexpected_idx: got idx %0h expected no index", idx);
      end else begin
        check("idx", idx, exp_q[0]);
        check("idx_last", idx_last, exp_last_q[0]);
        if (idx_ready) begin
          seen_q.push_back(idx);
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
    end
  end

  task automatic run_loop(input logic [31:0] s, l, st, input bit m, inc, input int brk_at,
                          input bit stall, output int nseen, output logic [31:0] last_seen,
                          output bit gb, output bit ge);
    bit eb, ee, done_due, hs_now;
    int total, hc, cyc;
    model(s, l, st, m, inc, ee);
    total = exp_q.size();
    eb = 1'b0;
    if (brk_at < total) begin
      while (exp_q.size() > brk_at + 1) begin
        void'(exp_q.pop_back());
        void'(exp_last_q.pop_back());
      end
      total = brk_at + 1;
      eb = 1'b1;
      ee = 1'b0;
    end
    seen_q.delete();
    gb = 1'b0;
    ge = 1'b0;

    @(negedge clk);
    check("cfg_ready_idle", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_start = s; cfg_limit = l; cfg_step = st; cfg_mul = m; cfg_incl = inc;
    idx_ready = 1'b0;
    brk = 1'b0;
    @(posedge clk);
    #1;
    cfg_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
    cfg_start = $urandom; cfg_limit = $urandom; cfg_step = $urandom;
    cfg_mul = 1'($urandom); cfg_incl = 1'($urandom);
    hc = 0;
    idx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    brk = idx_ready ? (hc == brk_at) : 1'($urandom_range(0, 1));

    done_due = (total == 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      check("done", done, done_due);
      if (done) begin
        check("brk_seen", brk_seen, eb);
        check("err_degen", err_degen, ee);
        gb = brk_seen;
        ge = err_degen;
        break;
      end
      if (done_due) break;
      if (cyc == 0) check("first_valid", idx_valid, total > 0);
      hs_now = idx_valid && idx_ready;
      if (hs_now) begin
        hc++;
        done_due = (hc == total);
      end
      cyc++;
      if (cyc > 3000) begin
        vec++;
        miss++;
        $display("FAIL loop_timeout: got %0d handshakes expected %0d", hc, total);
        break;
      end
      @(posedge clk);
      #1;
      idx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      brk = idx_ready ? (hc == brk_at) : 1'($urandom_range(0, 1));
      if (stall) cfg_valid = 1'($urandom_range(0, 1));
    end

    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    idx_ready = 1'b0;
    brk = 1'b0;
    @(negedge clk);
    check("cfg_ready_after", cfg_ready, 1'b1);
    check("done_pulse_end", done, 1'b0);
    check("leftover_expected", exp_q.size(), 0);
    nseen = seen_q.size();
    last_seen = (nseen > 0) ? seen_q[nseen - 1] : 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    check({tag, "_idx_valid"}, idx_valid, 1'b0);
    check({tag, "_idx"}, idx, 32'h0);
    check({tag, "_idx_last"}, idx_last, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_brk_seen"}, brk_seen, 1'b0);
    check({tag, "_err_degen"}, err_degen, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] lst, s, l, st;
    bit gb, ge, m, inc, dummy;

    // Reset block
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases with literal pins
    run_loop(0, 10, 1, 0, 0, 100, 0, n, lst, gb, ge);
    check("add_excl_count", n, 10);
    check("add_excl_last", lst, 9);
    check("add_excl_flags", {gb, ge}, 2'b00);

    run_loop(0, 10, 1, 0, 1, 100, 0, n, lst, gb, ge);
    check("add_incl_count", n, 11);
    check("add_incl_last", lst, 10);

    run_loop(0, 10, 2, 0, 0, 100, 0, n, lst, gb, ge);
    check("step2_count", n, 5);
    check("step2_last", lst, 8);

    run_loop(1, 10, 2, 1, 0, 100, 0, n, lst, gb, ge);
    check("mul_count", n, 4);
    check("mul_second", (n > 1) ? seen_q[1] : 32'hDEAD, 2);
    check("mul_last", lst, 8);
    check("mul_err", ge, 1'b0);

    run_loop(0, 10, 2, 1, 0, 100, 0, n, lst, gb, ge);
    check("mul_zero_count", n, 1);
    check("mul_zero_err", ge, 1'b1);

    run_loop(0, 10, 1, 0, 0, 3, 0, n, lst, gb, ge);
    check("brk_count", n, 4);
    check("brk_last", lst, 3);
    check("brk_seen_pin", gb, 1'b1);

    run_loop(0, 10, 1, 0, 0, 100, 1, n, lst, gb, ge);
    check("stall_count", n, 10);
    check("stall_brk_ignored", gb, 1'b0);

    run_loop(10, 10, 1, 0, 0, 100, 0, n, lst, gb, ge);
    check("zero_iter_count", n, 0);

    run_loop(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0, 100, 0, n, lst, gb, ge);
    check("ovf_count", n, 1);
    check("ovf_err", ge, 1'b1);

    // Reset mid-run: aborts immediately, no done, next descriptor works
    model(0, 1000, 1, 0, 0, dummy);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_start = 0; cfg_limit = 1000; cfg_step = 1; cfg_mul = 0; cfg_incl = 0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    idx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_last_q.delete();
    idx_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done, 1'b0);
    end
    rst = 1'b1;
    run_loop(3, 7, 1, 0, 1, 100, 0, n, lst, gb, ge);
    check("post_rst_count", n, 5);
    check("post_rst_last", lst, 7);

    // Random descriptors against the model
    for (int t = 0; t < 40; t++) begin
      m   = 1'($urandom);
      inc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        l = 32'hFFFF_FFFF - $urandom_range(0, 1);
        if (m) begin
          s  = 32'h4000_0000 + $urandom_range(0, 255);
          st = $urandom_range(0, 5);
        end else begin
          s  = 32'hFFFF_FF00 + $urandom_range(0, 255);
          st = $urandom_range(1, 64);
        end
      end else if (m) begin
        s  = $urandom_range(0, 5);
        st = $urandom_range(0, 4);
        l  = $urandom_range(0, 2000);
      end else begin
        s  = $urandom_range(0, 20);
        st = $urandom_range(0, 5);
        l  = $urandom_range(0, 40);
      end
      run_loop(s, l, st, m, inc, $urandom_range(0, 30), 1'($urandom), n, lst, gb, ge);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Sequential counterpart of a combinational `for` loop. It accepts one loop descriptor: start, limit, step, additive or multiplicative step, and exclusive or inclusive bound. It then emits the index sequence one value per handshake on a valid/ready stream and honours a consumer-side break request. It sits between a control/config master and any datapath that iterates over indices across clock cycles instead of unrolling them in one cycle.

## Interface
Parameters:
- `WIDTH`, default 32: width of index, start, limit and step.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: descriptor offered.
- `cfg_ready` out 1: descriptor accepted; high only in IDLE.
- `cfg_start` in WIDTH: first index, unsigned.
- `cfg_limit` in WIDTH: bound, unsigned.
- `cfg_step` in WIDTH: step amount.
- `cfg_mul` in 1: 0 means `i += step`, 1 means `i *= step`.
- `cfg_incl` in 1: 0 means `i < limit`, 1 means `i <= limit`.
- `idx_valid` out 1: index offered.
- `idx_ready` in 1: consumer takes index.
- `idx` out WIDTH: current index.
- `idx_last` out 1: current index is the final one; meaningful only with `idx_valid`.
- `brk` in 1: break request; sampled only on an idx handshake.
- `done` out 1: one-cycle pulse when the loop ends.
- `brk_seen` out 1: the last loop ended by `brk`; held until the next cfg accept.
- `err_degen` out 1: the last loop ended by overflow or a degenerate step; held until the next cfg accept.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid`, latch the descriptor, set `cur`=`cfg_start`, and clear `brk_seen` and `err_degen`.
  - If the bound test fails on `cfg_start`, go to DONE (zero iterations). Otherwise go to RUN.
- Bound test: `cur < limit` when `cfg_incl`=0, `cur <= limit` when `cfg_incl`=1. Comparison is unsigned.
- Next index:
  - Additive: `nxt = cur + step`, computed at WIDTH+1 bits.
  - Multiplicative: `nxt = cur * step`, computed at 2*WIDTH bits.
  - Carry or upper bits nonzero means overflow.
- Degenerate step: `nxt == cur`. This covers step 0 when additive, and step 1 or `cur`=0 when multiplicative.
- `idx_last` = (next index fails the bound test) OR overflow OR degenerate.
- RUN:
  - `idx_valid`=1 and `idx`=`cur`.
  - On `idx_valid && idx_ready`:
    - If `brk`, set `brk_seen`=1 and go to DONE.
    - Else if `idx_last`, set `err_degen`=(overflow OR degenerate) and go to DONE.
    - Else `cur` <= `nxt` and stay in RUN.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `brk` outside a handshake has no effect.

## Timing
- Reset values: state IDLE, `cfg_ready`=1, `idx_valid`=0, `idx`=0, `idx_last`=0, `done`=0, `brk_seen`=0, `err_degen`=0.
- All outputs are driven from registers or from state decode. `idx_last` is combinational from registered `cur` and the latched descriptor.
- Cfg handshake at edge N:
  - First `idx_valid` in cycle N+1.
  - In the zero-iteration case, `done` in cycle N+1 instead.
- With `idx_ready` held high, one index per cycle.
- Final handshake at edge M: `done` high in cycle M+1 and `cfg_ready` high again in cycle M+2.
- While `idx_valid && !idx_ready`, `idx` and `idx_last` hold stable. Valid is never withdrawn.
- `cfg_valid` in RUN or DONE is ignored.
- Asserting `rst` mid-loop aborts immediately to reset values. No `done` is produced.

## Structure
- Package `loop_seq_pkg`:
  - `loop_state_t` enum (IDLE, RUN, DONE).
  - `step_mode_t` enum (ADD, MUL).
  - `bound_mode_t` enum (EXCL, INCL).
- Sub-module `loop_seq_next`, purely combinational. It takes `cur`, step, mode and bound, and outputs `nxt`, `overflow`, `degen` and `last`.
- The top level holds the FSM, the descriptor registers and the status flags.

## Test plan
- start 0, limit 10, step 1, ADD, EXCL, `idx_ready`=1 -> idx 0..9 on consecutive cycles; `idx_last` only at 9; `done` the cycle after; flags 0.
- Same descriptor with INCL -> idx 0..10; `idx_last` at 10. With step 2 and EXCL -> 0,2,4,6,8.
- MUL, step 2, start 1, limit 10 -> 1,2,4,8. MUL with start 0 -> single idx 0, `idx_last`=1, `err_degen`=1.
- start 0, limit 10, `brk`=1 on the handshake of idx 3 -> idx 0..3 only, `done`, `brk_seen`=1. `brk` pulsed while `idx_ready`=0 -> ignored.
- start 10, limit 10, EXCL -> no `idx_valid`, `done` in cycle N+1. ADD with start 0xFFFFFFF0, step 0x20, limit 0xFFFFFFFF -> one idx, `err_degen`=1.
- Random `idx_ready` stalls -> `idx` stable while stalled, sequence unchanged. `rst` low mid-RUN -> all outputs at reset values, no `done`, and the next descriptor is accepted normally.
